fault_event_recorder: RTL and testbench

Downstream consumer of the per-rail state change loggers. Takes the sticky `ochange` mismatch vector, detects newly asserted bits and timestamps each new-fault event. Stores events in a small FIFO for the BMC/host register reader. Also latches the first-fault vector and flags lost events on overflow.

---
 rtl/fault_event_recorder.sv | 153 +++++++++++++++
 tb/tb_fault_event_recorder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_event_recorder.sv
`default_nettype none
// ============================================================================
// Module      : fault_event_recorder
// Description : Timestamps newly asserted fault bits into a small FIFO, and
//               tracks the first fault and any events dropped on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fault_event_recorder #(
    parameter int BITS  = 8,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic                       iClear,
    input  logic                       iTick,
    input  logic [BITS-1:0]            iChange,
    input  logic                       iRdReq,
    output logic [BITS+TS_W-1:0]       oRdData,
    output logic                       oRdValid,
    output logic                       oEmpty,
    output logic                       oFull,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic [BITS-1:0]            oFirstFault,
    output logic                       oFirstValid,
    output logic                       oOverflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = BITS + TS_W;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];

    logic [TS_W-1:0]  ts_q,          ts_d;
    logic [BITS-1:0]  chg_q,         chg_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [ENT_W-1:0] rd_data_q,     rd_data_d;
    logic             rd_valid_q,    rd_valid_d;
    logic [BITS-1:0]  first_fault_q, first_fault_d;
    logic             first_valid_q, first_valid_d;
    logic             overflow_q,    overflow_d;

    logic [BITS-1:0]  w_new_bits;
    logic             w_event;
    logic             w_pop;
    logic             w_push;
    logic             w_mem_we;

    assign w_new_bits = iChange & ~chg_q;
    assign w_event    = |w_new_bits;
    assign w_pop      = iRdReq && (count_q != '0);
    // A full FIFO still takes a new entry when the head leaves in the same cycle.
    assign w_push     = w_event && ((count_q != C_DEPTH) || w_pop);
    assign w_mem_we   = w_push && iClear;

    always_comb begin
        ts_d          = ts_q;
        chg_d         = chg_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        first_fault_d = first_fault_q;
        first_valid_d = first_valid_q;
        overflow_d    = overflow_q;

        if (!iClear) begin
            ts_d          = '0;
            chg_d         = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            rd_data_d     = '0;
            first_fault_d = '0;
            first_valid_d = 1'b0;
            overflow_d    = 1'b0;
        end else begin
            chg_d = iChange;
            if (iTick && (ts_q != '1)) begin
                ts_d = ts_q + 1'b1;
            end
            if (w_pop) begin
                rd_data_d  = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (w_event && !w_push) begin
                overflow_d = 1'b1;
            end
            if (w_event && !first_valid_q) begin
                first_fault_d = w_new_bits;
                first_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ts_q          <= '0;
            chg_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            first_fault_q <= '0;
            first_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            chg_q         <= chg_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            first_fault_q <= first_fault_d;
            first_valid_q <= first_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset term here.
    always_ff @(posedge iClk) begin
        if (w_mem_we) begin
            mem[wr_ptr_q] <= {w_new_bits, ts_q};
        end
    end

    assign oRdData     = rd_data_q;
    assign oRdValid    = rd_valid_q;
    assign oEmpty      = (count_q == '0);
    assign oFull       = (count_q == C_DEPTH);
    assign oCount      = count_q;
    assign oFirstFault = first_fault_q;
    assign oFirstValid = first_valid_q;
    assign oOverflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fault_event_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fault_event_recorder
// Description : Randomised and directed bench for fault_event_recorder with a
//               queue-based reference model and a decoupled scoreboard monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fault_event_recorder;

    localparam int BITS  = 8;
    localparam int DEPTH = 8;
    localparam int TS_W  = 8;
    localparam int ENT_W = BITS + TS_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              iClk = 1'b0;
    logic              iRst_n = 1'b0;
    logic              iClear = 1'b1;
    logic              iTick = 1'b0;
    logic [BITS-1:0]   iChange = '0;
    logic              iRdReq = 1'b0;
    logic [ENT_W-1:0]  oRdData;
    logic              oRdValid;
    logic              oEmpty;
    logic              oFull;
    logic [CNT_W-1:0]  oCount;
    logic [BITS-1:0]   oFirstFault;
    logic              oFirstValid;
    logic              oOverflow;

    fault_event_recorder #(.BITS(BITS), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iClear      (iClear),
        .iTick       (iTick),
        .iChange     (iChange),
        .iRdReq      (iRdReq),
        .oRdData     (oRdData),
        .oRdValid    (oRdValid),
        .oEmpty      (oEmpty),
        .oFull       (oFull),
        .oCount      (oCount),
        .oFirstFault (oFirstFault),
        .oFirstValid (oFirstValid),
        .oOverflow   (oOverflow)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int              cnt;
        logic [BITS-1:0] ff;
        logic            fv;
        logic            ov;
        logic            rdv;
        logic [ENT_W-1:0] last;
    } stat_t;

    stat_t            stat_q[$];
    logic [ENT_W-1:0] rdq[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [ENT_W-1:0] m_fifo[$];
    int               m_ts;
    logic [BITS-1:0]  m_prev;
    logic [BITS-1:0]  m_ff;
    logic             m_fv;
    logic             m_ov;
    logic             m_rdv;
    logic [ENT_W-1:0] m_last;
    logic [BITS-1:0]  cur_chg = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ts   = 0;
        m_prev = '0;
        m_ff   = '0;
        m_fv   = 1'b0;
        m_ov   = 1'b0;
        m_rdv  = 1'b0;
        m_last = '0;
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected status.
    task automatic cyc(input logic rst_n, input logic clr_n, input logic tick,
                       input logic [BITS-1:0] chg, input logic rd);
        logic [BITS-1:0] nb;
        stat_t s;
        iRst_n  = rst_n;
        iClear  = clr_n;
        iTick   = tick;
        iChange = chg;
        iRdReq  = rd;
        cur_chg = chg;
        if (!rst_n || !clr_n) begin
            model_reset();
        end else begin
            nb     = chg & ~m_prev;
            m_prev = chg;
            m_rdv  = 1'b0;
            if (rd && m_fifo.size() > 0) begin
                m_last = m_fifo.pop_front();
                m_rdv  = 1'b1;
                rdq.push_back(m_last);
            end
            if (nb != '0) begin
                if (!m_fv) begin
                    m_ff = nb;
                    m_fv = 1'b1;
                end
                if (m_fifo.size() < DEPTH) m_fifo.push_back({nb, TS_W'(m_ts)});
                else                       m_ov = 1'b1;
            end
            if (tick && m_ts < (1 << TS_W) - 1) m_ts++;
        end
        s.cnt  = m_fifo.size();
        s.ff   = m_ff;
        s.fv   = m_fv;
        s.ov   = m_ov;
        s.rdv  = m_rdv;
        s.last = m_last;
        stat_q.push_back(s);
        @(negedge iClk);
    endtask

    task automatic c(input logic tick, input logic [BITS-1:0] chg, input logic rd);
        cyc(1'b1, 1'b1, tick, chg, rd);
    endtask

    task automatic clr();
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic fill9();
        logic [BITS-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v = (v << 1) | 8'h01;
            c(1'b0, v, 1'b0);
        end
        c(1'b0, 8'h00, 1'b0);
        c(1'b0, 8'h01, 1'b0);
    endtask

    // Scoreboard monitor
    initial begin
        stat_t s;
        logic [ENT_W-1:0] e;
        forever begin
            @(posedge iClk);
            #1;
            if (stat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL status_queue_empty at %0t", $time);
            end else begin
                s = stat_q.pop_front();
                cmp("count", 32'(oCount), 32'(s.cnt));
                cmp("empty", 32'(oEmpty), 32'(s.cnt == 0));
                cmp("full", 32'(oFull), 32'(s.cnt == DEPTH));
                cmp("first_fault", 32'(oFirstFault), 32'(s.ff));
                cmp("first_valid", 32'(oFirstValid), 32'(s.fv));
                cmp("overflow", 32'(oOverflow), 32'(s.ov));
                cmp("rd_valid", 32'(oRdValid), 32'(s.rdv));
                cmp("rd_data_hold", 32'(oRdData), 32'(s.last));
            end
            if (oRdValid) begin
                checks++;
                if (rdq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop actual=%0h expected=none", oRdData);
                end else begin
                    e = rdq.pop_front();
                    if (oRdData !== e) begin
                        errors++;
                        $display("FAIL pop_data actual=%0h expected=%0h", oRdData, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [BITS-1:0] v;
        model_reset();
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // Ticks then one event, then pop it
        for (int i = 0; i < 5; i++) c(1'b1, 8'h00, 1'b0);
        c(1'b0, 8'h01, 1'b0);
        cmp("t1_count", 32'(oCount), 32'd1);
        cmp("t1_first", 32'(oFirstFault), 32'h01);
        c(1'b0, 8'h01, 1'b1);
        cmp("t1_pop", 32'(oRdData), 32'h0105);
        c(1'b0, 8'h01, 1'b0);
        cmp("t1_empty", 32'(oEmpty), 32'd1);

        // Two successive rising bits at different timestamps
        clr();
        c(1'b0, 8'h01, 1'b1);
        c(1'b1, 8'h01, 1'b1);
        c(1'b1, 8'h01, 1'b0);
        c(1'b1, 8'h03, 1'b0);
        c(1'b1, 8'h03, 1'b0);
        c(1'b0, 8'h07, 1'b0);
        c(1'b0, 8'h07, 1'b1);
        cmp("t2_pop0", 32'(oRdData), 32'h0202);
        c(1'b0, 8'h07, 1'b1);
        cmp("t2_pop1", 32'(oRdData), 32'h0404);
        c(1'b0, 8'h07, 1'b0);

        // Nine events into an 8-deep FIFO
        clr();
        fill9();
        cmp("t3_full", 32'(oFull), 32'd1);
        cmp("t3_count", 32'(oCount), 32'd8);
        cmp("t3_overflow", 32'(oOverflow), 32'd1);
        for (int i = 0; i < 8; i++) c(1'b0, 8'h01, 1'b1);
        c(1'b0, 8'h01, 1'b1);
        cmp("t3_drained", 32'(oEmpty), 32'd1);

        // Full FIFO with a same-cycle event and pop
        clr();
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v = (v << 1) | 8'h01;
            c(1'b0, v, 1'b0);
        end
        c(1'b0, 8'h00, 1'b0);
        c(1'b0, 8'h01, 1'b1);
        cmp("t4_count", 32'(oCount), 32'd8);
        cmp("t4_overflow", 32'(oOverflow), 32'd0);
        for (int i = 0; i < 8; i++) c(1'b0, 8'h01, 1'b1);

        // Reads on an empty FIFO
        clr();
        c(1'b0, 8'h10, 1'b0);
        c(1'b0, 8'h10, 1'b1);
        c(1'b0, 8'h10, 1'b1);
        cmp("t5_nopop_valid", 32'(oRdValid), 32'd0);
        cmp("t5_nopop_data", 32'(oRdData), 32'h1000);
        c(1'b0, 8'h30, 1'b1);
        cmp("t5_push_only", 32'(oCount), 32'd1);
        cmp("t5_push_novalid", 32'(oRdValid), 32'd0);

        // Clear, then reset, mid-run with entries, overflow and ts = 100
        for (int pass = 0; pass < 2; pass++) begin
            clr();
            fill9();
            for (int i = 0; i < 5; i++) c(1'b0, 8'h01, 1'b1);
            for (int i = 0; i < 100; i++) c(1'b1, 8'h01, 1'b0);
            cmp("t6_pre_count", 32'(oCount), 32'd3);
            if (pass == 0) clr();
            else           cyc(1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
            cmp("t6_count", 32'(oCount), 32'd0);
            cmp("t6_overflow", 32'(oOverflow), 32'd0);
            cmp("t6_first_valid", 32'(oFirstValid), 32'd0);
            c(1'b1, 8'h41, 1'b0);
            cmp("t6_refirst", 32'(oFirstFault), 32'h41);
            c(1'b0, 8'h41, 1'b1);
            cmp("t6_ts", 32'(oRdData), 32'h4100);
        end

        // Timestamp saturation
        clr();
        for (int i = 0; i < 300; i++) c(1'b1, 8'h00, 1'b0);
        c(1'b1, 8'h80, 1'b1);
        c(1'b0, 8'h80, 1'b1);
        cmp("t7_saturate", 32'(oRdData), 32'h80FF);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int phase;
            logic [BITS-1:0] nc;
            phase = (i / 250) % 3;
            nc = cur_chg;
            if ($urandom_range(0, 9) < 3) nc = nc ^ BITS'(1 << $urandom_range(0, BITS - 1));
            if ($urandom_range(0, 499) == 0)
                cyc(1'b0, 1'b1, 1'($urandom), nc, 1'($urandom));
            else if ($urandom_range(0, 299) == 0)
                cyc(1'b1, 1'b0, 1'($urandom), nc, 1'($urandom));
            else
                c(1'($urandom),
                  nc,
                  (phase == 0) ? ($urandom_range(0, 9) == 0) :
                  (phase == 1) ? ($urandom_range(0, 9) < 9) : 1'($urandom));
        end

        c(1'b0, cur_chg, 1'b0);
        cmp("scoreboard_drained", 32'(stat_q.size() + rdq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
